// File: rtl/pong_score_keeper.sv
// Pong game-state and scoring: serve timing, per-player scores and rally-driven speed level.
// Optional win limit enabled by defining KEEPER_WIN_LIMIT_EN.
module pong_score_keeper #(
    parameter int unsigned SERVE_TICKS    = 8,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_LEVEL      = 9,
    parameter int unsigned WIN_SCORE      = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_clock,
    input  logic       start,
    input  logic       hit,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [3:0] level,
    output logic       serve,
    output logic       playing,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;
`ifdef KEEPER_WIN_LIMIT_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q, hist_q;
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic [CNT_W-1:0]   rally_q, rally_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d, level_q, level_d;
    logic               serve_q, serve_d, playing_q, playing_d;
    logic               game_over_q, game_over_d, winner_q, winner_d;
    logic               step_c;
    logic [CNT_W-1:0]   quot_c;
    logic [SCORE_W-1:0] inc_l_c, inc_r_c;

    // Either edge of the synchronized game clock is one game step.
    assign step_c  = sync2_q ^ hist_q;
    assign inc_l_c = score_l_q + SCORE_W'(1);
    assign inc_r_c = score_r_q + SCORE_W'(1);

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        rally_d     = rally_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        level_d     = level_q;
        serve_d     = 1'b0;
        winner_d    = winner_q;
        quot_c      = '0;

        if (start) begin
            state_d     = S_SERVE;
            serve_cnt_d = CNT_W'(SERVE_TICKS);
            rally_d     = '0;
            score_l_d   = '0;
            score_r_d   = '0;
            level_d     = '0;
            winner_d    = 1'b0;
        end else begin
            case (state_q)
                S_SERVE: begin
                    if (step_c) begin
                        serve_cnt_d = serve_cnt_q - CNT_W'(1);
                        if (serve_cnt_q == CNT_W'(1)) begin
                            serve_d = 1'b1;
                            state_d = S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (miss_l || miss_r) begin
                        rally_d     = '0;
                        level_d     = '0;
                        serve_cnt_d = CNT_W'(SERVE_TICKS);
                        state_d     = S_SERVE;
                        // miss_l outranks miss_r; the missing side's opponent scores.
                        if (miss_l) begin
                            score_r_d = inc_r_c;
                            if (WIN_EN && inc_r_c == SCORE_W'(WIN_SCORE)) begin
                                state_d  = S_OVER;
                                winner_d = 1'b1;
                            end
                        end else begin
                            score_l_d = inc_l_c;
                            if (WIN_EN && inc_l_c == SCORE_W'(WIN_SCORE)) begin
                                state_d  = S_OVER;
                                winner_d = 1'b0;
                            end
                        end
                    end else if (hit) begin
                        if (rally_q != '1) begin
                            rally_d = rally_q + CNT_W'(1);
                        end
                        quot_c  = rally_d / CNT_W'(HITS_PER_LEVEL);
                        level_d = (quot_c > CNT_W'(MAX_LEVEL)) ? SCORE_W'(MAX_LEVEL)
                                                               : quot_c[SCORE_W-1:0];
                    end
                end
                default: ;
            endcase
        end

        playing_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            serve_cnt_q <= '0;
            rally_q     <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            level_q     <= '0;
            serve_q     <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= game_clock;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            serve_cnt_q <= serve_cnt_d;
            rally_q     <= rally_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            level_q     <= level_d;
            serve_q     <= serve_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign level     = level_q;
    assign serve     = serve_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with immediate-assertion checks.
module tb_pong_score_keeper;

    logic       clk = 1'b0;
    logic       rst_n, game_clock, start, hit, miss_l, miss_r;
    logic [3:0] score_l, score_r, level;
    logic       serve, playing, game_over, winner;
    int         errors = 0;
    int         checks = 0;

    pong_score_keeper #(
        .SERVE_TICKS(8), .HITS_PER_LEVEL(4), .MAX_LEVEL(9), .WIN_SCORE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_clock(game_clock), .start(start),
        .hit(hit), .miss_l(miss_l), .miss_r(miss_r),
        .score_l(score_l), .score_r(score_r), .level(level), .serve(serve),
        .playing(playing), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_hit();
        hit = 1'b1; cyc(1); hit = 1'b0;
    endtask

    task automatic pulse_ml();
        miss_l = 1'b1; cyc(1); miss_l = 1'b0;
    endtask

    task automatic pulse_mr();
        miss_r = 1'b1; cyc(1); miss_r = 1'b0;
    endtask

    // Eight game steps; serve must pulse exactly 3 clk after the 8th toggle.
    task automatic serve_seq();
        for (int t = 0; t < 7; t++) begin
            game_clock = ~game_clock;
            cyc(4);
            check("serve_early", 8'(serve), 8'd0);
        end
        check("playing_in_serve", 8'(playing), 8'd0);
        game_clock = ~game_clock;
        cyc(2);
        check("serve_pre", 8'(serve), 8'd0);
        cyc(1);
        check("serve_pulse", 8'(serve), 8'd1);
        cyc(1);
        check("serve_post", 8'(serve), 8'd0);
        check("playing_after_serve", 8'(playing), 8'd1);
    endtask

    initial begin
        rst_n = 1'b0; game_clock = 1'b0; start = 1'b0;
        hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        cyc(3);
        check("rst_score_l", 8'(score_l), 8'd0);
        check("rst_score_r", 8'(score_r), 8'd0);
        check("rst_level", 8'(level), 8'd0);
        check("rst_serve", 8'(serve), 8'd0);
        check("rst_playing", 8'(playing), 8'd0);
        check("rst_game_over", 8'(game_over), 8'd0);
        check("rst_winner", 8'(winner), 8'd0);
        rst_n = 1'b1;
        cyc(4);

        // Events outside PLAY are ignored.
        pulse_ml();
        check("idle_miss_ignored", 8'(score_r), 8'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        check("start_playing", 8'(playing), 8'd0);
        serve_seq();

        // Level steps every 4 hits and saturates at 9.
        for (int i = 1; i <= 40; i++) begin
            pulse_hit();
            check($sformatf("level_hit%0d", i), 8'(level), 8'((i / 4 > 9) ? 9 : i / 4));
        end

        pulse_mr();
        check("mr_score_l", 8'(score_l), 8'd1);
        check("mr_level", 8'(level), 8'd0);
        check("mr_playing", 8'(playing), 8'd0);
        pulse_hit();
        pulse_ml();
        check("serve_miss_ignored", 8'(score_r), 8'd0);
        serve_seq();

        // Simultaneous misses: only miss_l scores.
        miss_l = 1'b1; miss_r = 1'b1; cyc(1); miss_l = 1'b0; miss_r = 1'b0;
        check("both_score_r", 8'(score_r), 8'd1);
        check("both_score_l", 8'(score_l), 8'd1);
        serve_seq();

        // Hit with miss_l must not count towards the rally.
        repeat (3) pulse_hit();
        check("three_hits", 8'(level), 8'd0);
        hit = 1'b1; miss_l = 1'b1; cyc(1); hit = 1'b0; miss_l = 1'b0;
        check("hitmiss_score_r", 8'(score_r), 8'd2);
        check("hitmiss_level", 8'(level), 8'd0);
        serve_seq();
        repeat (3) pulse_hit();
        check("post_hitmiss_3", 8'(level), 8'd0);
        pulse_hit();
        check("post_hitmiss_4", 8'(level), 8'd1);

        // Reset mid-SERVE is immediate and suppresses the serve.
        pulse_mr();
        repeat (4) begin
            game_clock = ~game_clock;
            cyc(4);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_score_l", 8'(score_l), 8'd0);
        check("async_score_r", 8'(score_r), 8'd0);
        check("async_level", 8'(level), 8'd0);
        check("async_playing", 8'(playing), 8'd0);
        cyc(2);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            game_clock = ~game_clock;
            cyc(4);
            check("no_serve_after_rst", 8'(serve), 8'd0);
        end
        check("idle_after_rst", 8'(playing), 8'd0);

        start = 1'b1; cyc(1); start = 1'b0;
        serve_seq();
`ifdef KEEPER_WIN_LIMIT_EN
        for (int p = 1; p <= 3; p++) begin
            pulse_ml();
            check($sformatf("win_score_r%0d", p), 8'(score_r), 8'(p));
            if (p < 3) serve_seq();
        end
        check("win_game_over", 8'(game_over), 8'd1);
        check("win_winner", 8'(winner), 8'd1);
        check("win_playing", 8'(playing), 8'd0);
        pulse_ml();
        pulse_mr();
        check("over_score_r", 8'(score_r), 8'd3);
        check("over_score_l", 8'(score_l), 8'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        check("restart_score_r", 8'(score_r), 8'd0);
        check("restart_game_over", 8'(game_over), 8'd0);
        serve_seq();
`else
        // Without the win limit scores wrap modulo 16.
        for (int p = 1; p <= 16; p++) begin
            pulse_mr();
            check($sformatf("wrap_score_l%0d", p), 8'(score_l), 8'(p % 16));
            check("wrap_game_over", 8'(game_over), 8'd0);
            serve_seq();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
